instr_mem_ctrl: RTL
===================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, byte-address width of the fetch port.
REQ-002 SHALL have parameter DEPTH, default 256, number of 32-bit instruction words stored.
REQ-003 SHALL have parameter NOP_WORD, default 32'h0000_0013, word returned on a faulted fetch.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ld_valid  input  1  load byte present.
REQ-007 SHALL have port ld_byte  input  8  load byte, little-endian order.
REQ-008 SHALL have port ld_last  input  1  marks final load byte.
REQ-009 SHALL have port ld_ready  output  1  block accepts load bytes.
REQ-010 SHALL have port ld_ovf  output  1  sticky: bytes dropped past DEPTH.
REQ-011 SHALL have port fetch_req  input  1  fetch request.
REQ-012 SHALL have port fetch_addr  input  ADDR_W  byte address of the fetch.
REQ-013 SHALL have port fetch_rdy  output  1  block accepts fetches.
REQ-014 SHALL have port fetch_valid  output  1  fetch_data/fetch_fault valid.
REQ-015 SHALL have port fetch_data  output  32  fetched instruction.
REQ-016 SHALL have port fetch_fault  output  1  misaligned or out-of-range fetch.

Function
REQ-017 SHALL implement a two-state FSM: LOAD (after reset) and RUN.
REQ-018 In LOAD, ld_ready SHALL be 1 and fetch_rdy 0; in RUN, ld_ready 0 and fetch_rdy 1.
REQ-019 A byte SHALL be accepted when ld_valid and ld_ready are both 1; byte k of a word fills bits [8k+7:8k].
REQ-020 Each fourth accepted byte SHALL write the assembled word to word address wptr in the same cycle, then wptr increments.
REQ-021 An accepted byte with ld_last=1 SHALL write any partial word zero-padded in upper bytes, then move the FSM to RUN on the next edge.
REQ-022 Bytes accepted while wptr==DEPTH SHALL be discarded and set ld_ovf, which holds until reset.
REQ-023 ld_last while wptr==DEPTH SHALL still move the FSM to RUN.
REQ-024 A fetch SHALL be accepted when fetch_req and fetch_rdy are both 1; fetch_valid SHALL be 1 exactly one cycle later, else 0.
REQ-025 Back-to-back fetches SHALL be accepted every cycle with one response per accepted request, in order.
REQ-026 fetch_addr[1:0]!=0 or fetch_addr[ADDR_W-1:2]>=DEPTH SHALL yield fetch_fault=1 and fetch_data=NOP_WORD.
REQ-027 fetch_fault SHALL be 0 whenever fetch_valid is 0; fetch_data SHALL hold its last value when fetch_valid is 0.
REQ-028 Words never written since configuration SHALL read as NOP_WORD (initialised storage).

Reset
REQ-029 On rst: state=LOAD, wptr=0, byte lane=0, ld_ovf=0, fetch_valid=0, fetch_fault=0, fetch_data=0.
REQ-030 Reset mid-load SHALL discard a partially assembled word; words already written SHALL be retained.
REQ-031 Reset SHALL NOT clear the storage array.

Configuration
REQ-032 With INSTR_MEM_PARITY_EN defined, each stored word SHALL carry an even-parity bit computed at write and checked at fetch; a mismatch SHALL set fetch_fault=1 and return NOP_WORD.
REQ-033 Without INSTR_MEM_PARITY_EN, no parity storage or check SHALL exist and faults arise only from REQ-026.

Structure
REQ-034 NOP_WORD default, the LOAD/RUN state enum and the word width constant SHALL live in shared package instr_mem_pkg.
REQ-035 Storage SHALL be a sub-module instr_mem_array: one synchronous write port, one synchronous read port, parameterised by DEPTH and word width.

Verification
REQ-036 Load bytes 13 00 A0 00 with ld_last on the fourth -> word 0 = 0x00A00013; fetch 0x0 -> next cycle fetch_valid=1, data 0x00A00013, fault 0.
REQ-037 Load 6 bytes, ld_last on sixth -> word 1 = 0x0000BBAA-style zero-padded upper half; fetch 0x8 -> NOP_WORD (unwritten), fault 0.
REQ-038 In RUN, fetch 0x2 -> fault=1, data 0x00000013; fetch DEPTH*4 -> fault=1.
REQ-039 DEPTH=4, load 20 bytes -> ld_ovf=1 after byte 17, words 0..3 intact, RUN entered on ld_last.
REQ-040 Fetches 0x0,0x4,0x8 on consecutive cycles -> three consecutive fetch_valid pulses, data in order; assert rst mid-stream -> fetch_valid=0 next cycle, FSM in LOAD.
REQ-041 With INSTR_MEM_PARITY_EN, force a stored bit flip -> fetch of that word returns fault=1, NOP_WORD.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction memory controller.
//   WORD_W           : instruction word width
//   NOP_WORD_DEFAULT : word returned on a faulted fetch / never-written word
//   state_e          : LOAD (byte loading) / RUN (fetch serving)
//   even_parity()    : parity bit that makes the total count of ones even
package instr_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents start at INIT_WORD and are never cleared by reset.
// Ports:
//   clk              : clock
//   wr_en/wr_addr/wr_data : write port, takes effect on the rising edge
//   rd_en/rd_addr    : read request, data appears in rd_data after the edge
//   rd_data          : registered read data, holds while rd_en is low
module instr_mem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] INIT_WORD = '0,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  // Power-up contents model the initialised storage image.
  logic [WIDTH-1:0] mem_q [DEPTH] = '{default: INIT_WORD};
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: loads a little-endian byte stream into word
// storage (LOAD), then serves single-cycle-latency word fetches (RUN).
// Optional macro INSTR_MEM_PARITY_EN adds an even-parity bit per stored word,
// checked on every fetch.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   ld_valid/ld_byte/ld_last : load byte stream, ld_ready accepts
//   ld_ovf                   : sticky, a byte arrived with storage full
//   fetch_req/fetch_addr     : fetch request (byte address), fetch_rdy accepts
//   fetch_valid/fetch_data/fetch_fault : response one cycle after acceptance
//   dbg_state                : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid (ld_valid or
// fetch_req) and ready (ld_ready or fetch_rdy) are both 1; ready depends only
// on the FSM state, never on the valid input.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DEPTH = 256,
  parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_ovf,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_rdy,
  output logic              fetch_valid,
  output logic [WORD_W-1:0] fetch_data,
  output logic              fetch_fault,
  output state_e            dbg_state
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W-1:0] DEPTH_W = ADDR_W'(DEPTH);

`ifdef INSTR_MEM_PARITY_EN
  localparam int unsigned MEM_W = WORD_W + 1;
  localparam logic [MEM_W-1:0] MEM_INIT = {even_parity(NOP_WORD), NOP_WORD};
`else
  localparam int unsigned MEM_W = WORD_W;
  localparam logic [MEM_W-1:0] MEM_INIT = NOP_WORD;
`endif

  state_e            state_q, state_d;
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [1:0]        lane_q, lane_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              ld_ovf_q, ld_ovf_d;
  logic              fvalid_q, fvalid_d;
  logic              afault_q, afault_d;
  logic [WORD_W-1:0] fdata_hold_q, fdata_hold_d;

  logic              ld_acc, fetch_acc, full;
  logic              mem_we;
  logic [WORD_W-1:0] wdata_asm;
  logic [MEM_W-1:0]  mem_wdata, mem_rdata;
  logic              par_err, resp_fault;

  assign ld_ready  = (state_q == ST_LOAD);
  assign fetch_rdy = (state_q == ST_RUN);
  assign ld_acc    = ld_valid & ld_ready;
  assign fetch_acc = fetch_req & fetch_rdy;
  assign full      = (wptr_q == PW'(DEPTH));

  // Upper lanes of word_q are always zero, so a partial word is zero-padded.
  assign wdata_asm = word_q | (WORD_W'(ld_byte) << {lane_q, 3'b000});

`ifdef INSTR_MEM_PARITY_EN
  assign mem_wdata = {even_parity(wdata_asm), wdata_asm};
  assign par_err   = ^mem_rdata;
`else
  assign mem_wdata = wdata_asm;
  assign par_err   = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wptr_d   = wptr_q;
    lane_d   = lane_q;
    word_d   = word_q;
    ld_ovf_d = ld_ovf_q;
    mem_we   = 1'b0;
    if (ld_acc) begin
      if (full) begin
        ld_ovf_d = 1'b1;
      end else if (lane_q == 2'd3 || ld_last) begin
        mem_we = ~rst;
        wptr_d = wptr_q + 1'b1;
        lane_d = 2'd0;
        word_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        word_d = wdata_asm;
      end
      if (ld_last) state_d = ST_RUN;
    end
  end

  always_comb begin
    fvalid_d = fetch_acc;
    afault_d = fetch_acc &
               ((fetch_addr[1:0] != 2'b00) ||
                ({2'b00, fetch_addr[ADDR_W-1:2]} >= DEPTH_W));
    resp_fault   = afault_q | par_err;
    fetch_valid  = fvalid_q;
    fetch_fault  = fvalid_q & resp_fault;
    fetch_data   = fdata_hold_q;
    if (fvalid_q) fetch_data = resp_fault ? NOP_WORD : mem_rdata[WORD_W-1:0];
    fdata_hold_d = fetch_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      wptr_q       <= '0;
      lane_q       <= '0;
      word_q       <= '0;
      ld_ovf_q     <= 1'b0;
      fvalid_q     <= 1'b0;
      afault_q     <= 1'b0;
      fdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      ld_ovf_q     <= ld_ovf_d;
      fvalid_q     <= fvalid_d;
      afault_q     <= afault_d;
      fdata_hold_q <= fdata_hold_d;
    end
  end

  assign ld_ovf    = ld_ovf_q;
  assign dbg_state = state_q;

  instr_mem_array #(
    .DEPTH    (DEPTH),
    .WIDTH    (MEM_W),
    .INIT_WORD(MEM_INIT)
  ) u_array (
    .clk    (clk),
    .wr_en  (mem_we),
    .wr_addr(wptr_q[AW-1:0]),
    .wr_data(mem_wdata),
    .rd_en  (fetch_acc),
    .rd_addr(fetch_addr[AW+1:2]),
    .rd_data(mem_rdata)
  );

endmodule
